// File: rtl/alu_op_sequencer_if.sv
// Command, result and Arithmetic-unit signals of alu_op_sequencer.
// master: the sequencer; slave: the host plus the Arithmetic unit it drives.
interface alu_op_sequencer_if;
    // Command channel: a command moves on a rising edge where cmd_valid && cmd_ready.
    // The source holds cmd_op/cmd_operand stable while cmd_valid is high and not yet accepted.
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_operand;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_opcode;
    logic [3:0] alu_out;
    logic       alu_c;
    logic       alu_v;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_c;
    logic       res_v;
    logic       sticky_v;
    logic       bad_op;
    logic       busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_operand, alu_out, alu_c, alu_v,
        output cmd_ready, alu_a, alu_b, alu_opcode,
        output res_valid, res_data, res_c, res_v, sticky_v, bad_op, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_operand, alu_out, alu_c, alu_v,
        input  cmd_ready, alu_a, alu_b, alu_opcode,
        input  res_valid, res_data, res_c, res_v, sticky_v, bad_op, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command FIFO feeding a 4-bit Arithmetic unit one command at a time; the result
// is captured into an accumulator and flag registers and reported with a valid pulse.
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_op_sequencer_if.master   bus,
    output logic                 state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_CLRF = 3'd5;

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [6:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [2:0]    cur_op_q;
    logic [3:0]    cur_operand_q;
    logic [3:0]    acc_q;
    logic          res_valid_q, res_c_q, res_v_q, sticky_v_q, bad_op_q;
    logic          full, empty, push, pop;
    logic [3:0]    alu_b_d, alu_opcode_d;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.cmd_valid && !full;
    assign pop   = (state_q == IDLE) && !empty;

    always_comb begin
        state_d      = state_q;
        alu_b_d      = 4'b0000;
        alu_opcode_d = 4'b0000;
        case (state_q)
            IDLE: if (!empty) state_d = EXEC;
            EXEC: begin
                state_d = IDLE;
                alu_b_d = cur_operand_q;
                case (cur_op_q)
                    OP_ADD:  alu_opcode_d = 4'b0100;
                    OP_INC:  alu_opcode_d = 4'b0101;
                    OP_SUB:  alu_opcode_d = 4'b0110;
                    OP_DEC:  alu_opcode_d = 4'b0111;
                    default: alu_opcode_d = 4'b0000;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage carries no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_operand};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cur_op_q      <= 3'd0;
            cur_operand_q <= 4'd0;
            acc_q         <= 4'd0;
            res_valid_q   <= 1'b0;
            res_c_q       <= 1'b0;
            res_v_q       <= 1'b0;
            sticky_v_q    <= 1'b0;
            bad_op_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (pop) begin
                cur_op_q      <= mem_q[rd_ptr_q][6:4];
                cur_operand_q <= mem_q[rd_ptr_q][3:0];
            end
            res_valid_q <= (state_q == EXEC);
            bad_op_q    <= 1'b0;
            if (state_q == EXEC) begin
                case (cur_op_q)
                    OP_ADD, OP_INC, OP_SUB, OP_DEC: begin
                        acc_q      <= bus.alu_out;
                        res_c_q    <= bus.alu_c;
                        res_v_q    <= bus.alu_v;
                        sticky_v_q <= sticky_v_q | bus.alu_v;
                    end
                    OP_LOAD: begin
                        acc_q   <= cur_operand_q;
                        res_c_q <= 1'b0;
                        res_v_q <= 1'b0;
                    end
                    OP_CLRF: begin
                        sticky_v_q <= 1'b0;
                        res_c_q    <= 1'b0;
                        res_v_q    <= 1'b0;
                    end
                    default: bad_op_q <= 1'b1;
                endcase
            end
        end
    end

    assign bus.cmd_ready  = !full;
    assign bus.alu_a      = acc_q;
    assign bus.alu_b      = alu_b_d;
    assign bus.alu_opcode = alu_opcode_d;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = acc_q;
    assign bus.res_c      = res_c_q;
    assign bus.res_v      = res_v_q;
    assign bus.sticky_v   = sticky_v_q;
    assign bus.bad_op     = bad_op_q;
    assign bus.busy       = !empty || (state_q != IDLE);
    assign state_o        = state_q;
endmodule
